// File: rtl/madd_pkg.sv
// Shared types and helpers for the multicycle adder.
package madd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2 with a floor of 1, so a single-chunk counter still has one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32'd31; i++) begin
         if ((32'd1 << i) < n) r = i + 32'd1;
      end
      return (r == 0) ? 32'd1 : r;
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple-carry adder for one CHUNK-bit slice.
module chunk_adder #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   // Ripple of full-adder cells; c[i] is the carry into bit i.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit adder that processes CHUNK bits per clock through a registered
// carry, with valid/ready handshakes on both input and output.
module multicycle_adder
   import madd_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = clog2(NCHUNK);

   // Reject parameter sets that do not split WIDTH into whole chunks.
   if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("multicycle_adder: CHUNK must be in 1..WIDTH and divide WIDTH");
   end

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             step;
   logic             last;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [CHUNK-1:0] s;
   logic             co;
   logic             c_msb;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .x     (a_sh[CHUNK-1:0]),
      .y     (b_sh[CHUNK-1:0]),
      .ci    (carry),
      .s     (s),
      .co    (co),
      .c_msb (c_msb)
   );

   // New chunk enters the sum register at the MSB end.
   if (CHUNK == WIDTH) begin : g_sum_single
      assign sum_nxt = s;
   end else begin : g_sum_shift
      assign sum_nxt = {s, sum[WIDTH-1:CHUNK]};
   end

   // Ready depends only on state (and reset), never on out_ready.
   assign in_ready = (state == IDLE) && !rst;
   assign last     = (cnt == CW'(NCHUNK - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and datapath control.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand shifters, carry chain, counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         sum       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= (state_nxt == DONE);
         if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
         end
         if (step) begin
            a_sh  <= a_sh >> CHUNK;
            b_sh  <= b_sh >> CHUNK;
            sum   <= sum_nxt;
            carry <= co;
            cnt   <= cnt + CW'(1);
            if (last) begin
               cout <= co;
               ovf  <= co ^ c_msb;
            end
         end
      end
   end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed and random checks of multicycle_adder with an in-order scoreboard.
module tb_multicycle_adder;

   logic       clk;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, sum;
   logic       cin, cout, ovf;

   // Sweep instances share one stimulus set.
   logic       sw_valid, sw_cin, sw_oready;
   logic [7:0] sw_a, sw_b;
   logic [3:0] sw_ready, sw_ov, sw_cout, sw_ovf;
   logic [7:0] sw_sum [4];
   logic [0:0] w1_sum;

   int         total, bad, cyc, acc_cyc, rise_cyc, n_acc, n_del, sw_acc;
   logic       acc_flag, ov_prev;
   logic [9:0] last_obs;
   logic [9:0] sbq [$];
   int         sw_rise [4];
   int         sw_cnt [4];
   logic [9:0] sw_res [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   multicycle_adder #(.WIDTH(8), .CHUNK(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   multicycle_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[0]),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(sw_ov[0]), .out_ready(sw_oready),
      .sum(sw_sum[0]), .cout(sw_cout[0]), .ovf(sw_ovf[0])
   );

   multicycle_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[1]),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(sw_ov[1]), .out_ready(sw_oready),
      .sum(sw_sum[1]), .cout(sw_cout[1]), .ovf(sw_ovf[1])
   );

   multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[2]),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(sw_ov[2]), .out_ready(sw_oready),
      .sum(sw_sum[2]), .cout(sw_cout[2]), .ovf(sw_ovf[2])
   );

   multicycle_adder #(.WIDTH(1), .CHUNK(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ready[3]),
      .a(sw_a[0:0]), .b(sw_b[0:0]), .cin(sw_cin), .out_valid(sw_ov[3]), .out_ready(sw_oready),
      .sum(w1_sum), .cout(sw_cout[3]), .ovf(sw_ovf[3])
   );

   assign sw_sum[3] = {7'd0, w1_sum};

   // Golden {ovf, cout, sum}: plain 9-bit add, overflow from operand/result signs.
   function automatic logic [9:0] gold(input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [8:0] t;
      t = {1'b0, x} + {1'b0, y} + {8'd0, c};
      return {(x[7] == y[7]) && (t[7] != x[7]), t[8], t[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe handshakes just after the falling edge, then advance.
   task automatic step();
      #1;
      acc_flag = 1'b0;
      if (in_valid && in_ready) begin
         sbq.push_back(gold(a, b, cin));
         acc_cyc  = cyc;
         acc_flag = 1'b1;
         n_acc++;
      end
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
         n_del++;
         chk("queue_nonempty", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            last_obs = {ovf, cout, sum};
            chk("result", 32'(last_obs), 32'(sbq.pop_front()));
         end
      end
      if (sw_valid) sw_acc = cyc;
      for (int i = 0; i < 4; i++) begin
         if (sw_ov[i]) begin
            sw_cnt[i]++;
            if (sw_rise[i] < 0) begin
               sw_rise[i] = cyc;
               sw_res[i]  = {sw_ovf[i], sw_cout[i], sw_sum[i]};
            end
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_add(input logic [7:0] x, input logic [7:0] y, input logic c);
      int n;
      a = x; b = y; cin = c; in_valid = 1'b1;
      n = 0;
      do begin step(); n++; end while (!acc_flag && n < 50);
      chk("accept_timeout", 32'(acc_flag), 32'd1);
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      n = 0;
      while (sbq.size() != 0 && n < 50) begin step(); n++; end
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      int n, p, sent, del0;
      int exp_lat [4];
      total = 0; bad = 0; cyc = 0; n_acc = 0; n_del = 0;
      acc_cyc = 0; rise_cyc = 0; sw_acc = 0; ov_prev = 1'b0; last_obs = '0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      sw_valid = 1'b0; sw_oready = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0;
      for (int i = 0; i < 4; i++) begin sw_rise[i] = -1; sw_cnt[i] = 0; sw_res[i] = '0; end
      exp_lat[0] = 8; exp_lat[1] = 4; exp_lat[2] = 1; exp_lat[3] = 1;

      // Reset state.
      @(negedge clk);
      step(); step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // Test 1: carry out, latency 2.
      do_add(8'hFF, 8'h01, 1'b0);
      chk("t1_res", 32'(last_obs), 32'({1'b0, 1'b1, 8'h00}));
      chk("t1_latency", 32'(rise_cyc - 1 - acc_cyc), 32'd2);

      // Test 2: signed overflow both ways, plus back-to-back spacing.
      do_add(8'h7F, 8'h01, 1'b0);
      chk("t2a_res", 32'(last_obs), 32'({1'b1, 1'b0, 8'h80}));
      p = acc_cyc;
      do_add(8'h80, 8'h80, 1'b1);
      chk("t2b_res", 32'(last_obs), 32'({1'b1, 1'b1, 8'h01}));
      chk("throughput", 32'(acc_cyc - p), 32'd4);

      // Test 3: back-pressure in DONE.
      out_ready = 1'b0;
      a = 8'h3C; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
      n = 0;
      do begin step(); n++; end while (!acc_flag && n < 50);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      chk("t3_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 32'(out_valid), 32'd1);
         chk("t3_hold_sum", 32'(sum), 32'h4B);
         chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk("t3_res", 32'(last_obs), 32'({1'b0, 1'b0, 8'h4B}));
      chk("t3_after_valid", 32'(out_valid), 32'd0);
      chk("t3_after_in_ready", 32'(in_ready), 32'd1);

      // Test 4: reset in the first RUN cycle discards the add.
      a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
      n = 0;
      do begin step(); n++; end while (!acc_flag && n < 50);
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      sbq.delete();
      del0 = n_del;
      for (int i = 0; i < 8; i++) begin
         chk("t4_no_valid", 32'(out_valid), 32'd0);
         step();
      end
      chk("t4_no_delivery", 32'(n_del - del0), 32'd0);
      do_add(8'h0A, 8'h05, 1'b1);
      chk("t4_res", 32'(last_obs), 32'({1'b0, 1'b0, 8'h10}));

      // Test 5: random operands and random back-pressure.
      sent = 0; del0 = n_del; n = 0;
      while ((sent < 100 || sbq.size() != 0) && n < 5000) begin
         if (!in_valid && sent < 100) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         end
         out_ready = 1'($urandom_range(0, 1));
         step(); n++;
         if (acc_flag) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      chk("t5_sent", 32'(sent), 32'd100);
      chk("t5_delivered", 32'(n_del - del0), 32'd100);
      chk("t5_queue_empty", 32'(sbq.size()), 32'd0);
      out_ready = 1'b1;

      // Test 6: chunk sweep and WIDTH=1.
      for (int i = 0; i < 4; i++) begin
         chk("t6_ready", 32'(sw_ready[i]), 32'd1);
         sw_rise[i] = -1; sw_cnt[i] = 0;
      end
      sw_a = 8'hAA; sw_b = 8'h55; sw_cin = 1'b1; sw_valid = 1'b1;
      step();
      sw_valid = 1'b0; sw_a = 8'($urandom); sw_b = 8'($urandom); sw_cin = 1'($urandom);
      for (int i = 0; i < 15; i++) step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t6_latency%0d", i), 32'(sw_rise[i] - 1 - sw_acc), 32'(exp_lat[i]));
         chk($sformatf("t6_res%0d", i), 32'(sw_res[i]), 32'({1'b0, 1'b1, 8'h00}));
         chk($sformatf("t6_pulse%0d", i), 32'(sw_cnt[i]), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
